// File: rtl/ice_pll_seq.sv
// ice_pll_seq: iCE40 PLL bring-up and supervision sequencer (PLL reset, lock wait, stability, retry).
// Build option ICE_PLL_BYPASS_FALLBACK_EN: after retries run the PLL domain from the bypass path.
module ice_pll_seq #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 13
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  output logic       o_pll_resetb,
  output logic       o_pll_bypass,
  output logic       o_domain_reset,
  output logic       o_ready,
  output logic       o_fail,
  output logic [7:0] o_lost_cnt,
  output logic [2:0] o_state
);

  // state  | meaning
  // PRST   | PLL held in reset for RESET_CYCLES
  // WAIT   | PLL released, waiting for synced lock or timeout
  // STABLE | counting consecutive lock cycles
  // RUN    | domain out of reset, supervising lock
  // RETRY  | one-cycle retry bookkeeping
  // FAIL   | retries exhausted, parked until reset
  // BYPASS | retries exhausted, domain clocked via PLL bypass
  typedef enum logic [2:0] {
    S_PRST   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_RETRY  = 3'd4,
    S_FAIL   = 3'd5,
    S_BYPASS = 3'd6
  } state_t;

  localparam int RTR_W     = $clog2(MAX_RETRIES + 1);
  localparam int BYP_PULSE = 8;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RTR_W-1:0]   r_retries;
  logic [7:0]         r_lost;
  logic               r_lock_meta;
  logic               r_lock_s;
  logic               r_pll_resetb;
  logic               r_pll_bypass;
  logic               r_domain_reset;
  logic               r_ready;
  logic               r_fail;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [RTR_W-1:0]   w_retries_inc;
  logic [7:0]         w_lost_sat;

  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_retries_inc = r_retries + 1'b1;
  assign w_lost_sat    = (r_lost == 8'hFF) ? r_lost : r_lost + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_PRST;
      r_cnt          <= '0;
      r_retries      <= '0;
      r_lost         <= '0;
      r_lock_meta    <= 1'b0;
      r_lock_s       <= 1'b0;
      r_pll_resetb   <= 1'b0;
      r_pll_bypass   <= 1'b0;
      r_domain_reset <= 1'b1;
      r_ready        <= 1'b0;
      r_fail         <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
      case (r_state)
        S_PRST: begin
          if (w_cnt_inc == CNT_W'(RESET_CYCLES)) begin
            r_state      <= S_WAIT;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        // lock is checked before the timeout so a coincident lock wins
        S_WAIT: begin
          if (r_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (w_cnt_inc == CNT_W'(LOCK_TIMEOUT)) begin
            r_state <= S_RETRY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else if (w_cnt_inc == CNT_W'(STABLE_CYCLES)) begin
            r_state        <= S_RUN;
            r_cnt          <= '0;
            r_ready        <= 1'b1;
            r_domain_reset <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            r_state        <= S_PRST;
            r_cnt          <= '0;
            r_ready        <= 1'b0;
            r_domain_reset <= 1'b1;
            r_pll_resetb   <= 1'b0;
            r_lost         <= w_lost_sat;
            r_retries      <= '0;
          end
        end
        S_RETRY: begin
          r_retries    <= w_retries_inc;
          r_cnt        <= '0;
          r_pll_resetb <= 1'b0;
          if (w_retries_inc == RTR_W'(MAX_RETRIES)) begin
`ifdef ICE_PLL_BYPASS_FALLBACK_EN
            r_state      <= S_BYPASS;
            r_pll_bypass <= 1'b1;
            r_fail       <= 1'b1;
`else
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
`endif
          end else begin
            r_state <= S_PRST;
          end
        end
`ifdef ICE_PLL_BYPASS_FALLBACK_EN
        // domain reset pulse while the bypassed clock settles, then hold
        S_BYPASS: begin
          if (!r_ready) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(BYP_PULSE)) begin
              r_ready        <= 1'b1;
              r_domain_reset <= 1'b0;
            end
          end
        end
`else
        S_FAIL: begin
          r_state <= S_FAIL;
        end
`endif
        default: begin
          r_state        <= S_PRST;
          r_cnt          <= '0;
          r_pll_resetb   <= 1'b0;
          r_pll_bypass   <= 1'b0;
          r_domain_reset <= 1'b1;
          r_ready        <= 1'b0;
          r_fail         <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_resetb   = r_pll_resetb;
  assign o_pll_bypass   = r_pll_bypass;
  assign o_domain_reset = r_domain_reset;
  assign o_ready        = r_ready;
  assign o_fail         = r_fail;
  assign o_lost_cnt     = r_lost;
  assign o_state        = r_state;

endmodule
